inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 159 +++++++++++++++
 tb/tb_inst_queue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue -- instruction queue between the fetch stage and the decoder.
//
// A circular buffer of DEPTH entries. Each entry holds {pc, ins, exc}. There is
// a read pointer, a write pointer and an occupancy counter. A flush (branch
// redirect or exception) empties the queue in one cycle.
//
// Optional feature (compile-time macro IQ_BYPASS_EN):
//   defined   : when the queue is empty and no flush is active, the presented
//               fetch word passes straight to out_*. If the decoder takes it
//               that cycle it is never stored; otherwise it is written as usual.
//   undefined : out_* depend only on registered state, so a word pushed in
//               cycle N reaches the head in cycle N+1 at the earliest.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   synchronous active-low reset
//   in_valid   in   fetch presents a word
//   in_ready   out  queue can accept a word (not full; ignores out_ready)
//   in_pc      in   [31:0] fetch address
//   in_ins     in   [31:0] instruction word
//   in_exc     in   fetch exception tag
//   flush      in   discard all contents (overrides push and pop)
//   out_valid  out  head entry valid for the decoder
//   out_ready  in   decoder consumes the head
//   out_pc     out  [31:0] head PC (0 while out_valid=0)
//   out_ins    out  [31:0] head instruction (0, a NOP, while out_valid=0)
//   out_exc    out  head exception flag (0 while out_valid=0)
//   count      out  [$clog2(DEPTH):0] number of occupied entries
// -----------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_ins,
    input  logic                     in_exc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_ins,
    output logic                     out_exc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 65;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];

    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] head_s;

    // Status flags and the write-side handshake, all from registered state.
    always_comb begin
        empty_s  = (count_q == {CW{1'b0}});
        full_s   = (count_q == CW'(DEPTH));
        in_ready = ~full_s;
        push_s   = in_valid & ~full_s;
        head_s   = mem_q[rd_ptr_q];
    end

    // Head presentation; fields are forced to zero whenever nothing is valid.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = 32'h0000_0000;
        out_ins   = 32'h0000_0000;
        out_exc   = 1'b0;
`ifdef IQ_BYPASS_EN
        if (empty_s && !flush && in_valid) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_ins   = in_ins;
            out_exc   = in_exc;
        end else if (!empty_s) begin
            out_valid = 1'b1;
            out_pc    = head_s[64:33];
            out_ins   = head_s[32:1];
            out_exc   = head_s[0];
        end else begin
            out_valid = 1'b0;
        end
`else
        if (!empty_s) begin
            out_valid = 1'b1;
            out_pc    = head_s[64:33];
            out_ins   = head_s[32:1];
            out_exc   = head_s[0];
        end else begin
            out_valid = 1'b0;
        end
`endif
        pop_s = out_valid & out_ready;
        count = count_q;
    end

    // Next-state for pointers, counter and storage. A bypassed word that is
    // consumed looks like push+pop at count 0: both pointers advance, count
    // stays 0, and the written slot is never observed.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = {in_pc, in_ins, in_exc};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only visible through valid entries, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_ins;
    logic        in_exc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;
    logic        out_exc;
    logic [$clog2(DEPTH):0] count;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ins(in_ins), .in_exc(in_exc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ins(out_ins), .out_exc(out_exc),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference: the queue contents in FIFO order, {pc, ins, exc}.
    logic [64:0] exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  started = 1'b0;
    bit  exp_ready = 1'b1;
    bit  byp_consumed = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: away from the active edge, compare the presented head with the reference.
    initial begin
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eins;
        logic        eexc;
        forever begin
            @(negedge clk);
            if (started && resetn) begin
                ev = 1'b0; epc = 32'h0; eins = 32'h0; eexc = 1'b0;
                if (exp_q.size() != 0) begin
                    ev   = 1'b1;
                    epc  = exp_q[0][64:33];
                    eins = exp_q[0][32:1];
                    eexc = exp_q[0][0];
                end
`ifdef IQ_BYPASS_EN
                else if (!flush && in_valid) begin
                    ev = 1'b1; epc = in_pc; eins = in_ins; eexc = in_exc;
                end
`endif
                chk("count",     64'(count),     64'(exp_q.size()));
                chk("in_ready",  64'(in_ready),  64'(exp_q.size() != DEPTH));
                chk("out_valid", 64'(out_valid), 64'(ev));
                chk("out_pc",    64'(out_pc),    64'(epc));
                chk("out_ins",   64'(out_ins),   64'(eins));
                chk("out_exc",   64'(out_exc),   64'(eexc));
                exp_ready    = (exp_q.size() != DEPTH);
                byp_consumed = 1'b0;
                if (ev && out_ready && !flush) begin
                    if (exp_q.size() == 0) byp_consumed = 1'b1;
                    else void'(exp_q.pop_front());
                end
            end
        end
    end

    // Reference update at the active edge: reset/flush clear, accepted words append.
    initial begin
        forever begin
            @(posedge clk);
            if (!resetn || flush) exp_q.delete();
            else if (in_valid && exp_ready && !byp_consumed)
                exp_q.push_back({in_pc, in_ins, in_exc});
            started = 1'b1;
        end
    end

    task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ex, input logic fl, input logic ordy);
        in_valid = iv; in_pc = pc; in_ins = ins; in_exc = ex; flush = fl; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_ins = 32'h0;
        in_exc = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // First word reaches the head one cycle later.
        cyc(1'b1, 32'hBFC0_0000, 32'h2401_0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Five pushes into four entries, then drain in order.
        for (int i = 1; i <= 5; i++)
            cyc(1'b1, 32'h0000_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Refill, then pop while full with a word presented: push refused.
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 32'h0000_2000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_3000, 32'hC000_0006, 1'b0, 1'b0, 1'b1);
        // Flush with three entries and a simultaneous push.
        cyc(1'b1, 32'h0000_4000, 32'hD000_0007, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Exception-tagged word travels with its entry.
        cyc(1'b1, 32'h0000_0003, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Empty queue with word presented and decoder ready.
        cyc(1'b1, 32'h0000_5000, 32'hE000_0008, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 800; i++) begin
            resetn = ($urandom_range(0, 99) != 0);
            cyc(($urandom_range(0, 3) != 0), $urandom, $urandom, ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0));
        end
        resetn = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
